// File: rtl/spi_reg_responder.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// spi_reg_responder
//
// SPI responder (slave end) fronting a small byte-wide register bank. A frame
// is a command byte {RW, ADDR[6:0]} followed by data byte(s), MSB first, with
// CS active low. RW=1 writes the data byte into regs[ADDR]; RW=0 returns
// regs[ADDR] on MISO. ID_BYTE is shifted out during every command byte.
// SCLK, CS and MOSI are oversampled in the clk domain (clk >= 8x SCLK).
//
// Build option:
//   SPI_RSP_AUTOINC_EN  when defined, the address auto-increments after every
//                       data byte (7-bit wrap) so bursts of any length work.
//                       When undefined, the frame ends after one data byte and
//                       the responder idles in DONE until CS rises.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   asynchronous active-high reset
//   SPI_SCLK  in   SPI clock from the master (asynchronous)
//   CS        in   chip select, active low
//   MOSI      in   master out, slave in
//   MISO      out  slave out, 0 while not selected
//   CPOL      in   SCLK idle level, captured at CS fall
//   CPHA      in   0: sample leading / shift trailing, 1: the reverse
//   busy      out  high while a frame is in progress
//   wr_pulse  out  1-clk strobe per committed register write
//   wr_addr   out  address of the last committed write
//   regs      out  flat register bank, reg n at [8n+7:8n]
// -----------------------------------------------------------------------------
module spi_reg_responder #(
    parameter int         REG_COUNT = 8,
    parameter logic [7:0] ID_BYTE   = 8'hA5,
    parameter logic [7:0] RST_VAL   = 8'h00
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   SPI_SCLK,
    input  logic                   CS,
    input  logic                   MOSI,
    output logic                   MISO,
    input  logic                   CPOL,
    input  logic                   CPHA,
    output logic                   busy,
    output logic                   wr_pulse,
    output logic [6:0]             wr_addr,
    output logic [8*REG_COUNT-1:0] regs
);

    typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;

    // 8-bit limit so REG_COUNT = 128 compares correctly against a 7-bit address
    localparam logic [7:0] REG_LIMIT = 8'(REG_COUNT);

    // synchronizers and edge history
    logic [1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
    logic       sclk_prev_q, cs_prev_q;

    // frame state
    state_t                    state_q, state_d;
    logic [2:0]                bit_cnt_q, bit_cnt_d;
    logic [6:0]                rx_q, rx_d;      // previous 7 bits; 8th comes from MOSI
    logic [7:0]                tx_q, tx_d;
    logic [6:0]                addr_q, addr_d;
    logic                      rw_q, rw_d;
    logic                      cpol_q, cpol_d;
    logic                      cpha_q, cpha_d;
    logic [REG_COUNT-1:0][7:0] regs_q, regs_d;
    logic                      wr_pulse_q, wr_pulse_d;
    logic [6:0]                wr_addr_q, wr_addr_d;

    // derived strobes
    logic       sclk_s, cs_s, mosi_s;
    logic       sclk_rise, sclk_fall, lead_edge, trail_edge;
    logic       sample_edge, shift_edge;
    logic       cs_fall, cs_rise;
    logic [7:0] shift_in;
    logic [7:0] rd_data;
    logic [7:0] tx_load;
    logic       in_range;

    assign sclk_s = sclk_sync_q[1];
    assign cs_s   = cs_sync_q[1];
    assign mosi_s = mosi_sync_q[1];

    assign sclk_rise  = sclk_s & ~sclk_prev_q;
    assign sclk_fall  = ~sclk_s & sclk_prev_q;
    // leading edge leaves the idle level, trailing edge returns to it
    assign lead_edge  = cpol_q ? sclk_fall : sclk_rise;
    assign trail_edge = cpol_q ? sclk_rise : sclk_fall;
    assign sample_edge = cpha_q ? trail_edge : lead_edge;
    assign shift_edge  = cpha_q ? lead_edge  : trail_edge;

    assign cs_fall = ~cs_s & cs_prev_q;
    assign cs_rise = cs_s & ~cs_prev_q;

    assign shift_in = {rx_q, mosi_s};
    assign in_range = ({1'b0, addr_q} < REG_LIMIT);

    // read mux; addresses with no register return 0
    always_comb begin
        rd_data = 8'h00;
        for (int n = 0; n < REG_COUNT; n++) begin
            if (addr_q == 7'(n)) rd_data = regs_q[n];
        end
    end

    // Byte presented at the first shift edge of a byte. The first shift edge
    // of each byte (bit_cnt == 0) reloads instead of shifting: for CPHA=0 that
    // is the trailing edge after the previous byte's last sample, which puts
    // bit 7 out before the byte's first leading edge; for CPHA=1 it is the
    // byte's first leading edge itself.
    assign tx_load = (state_q == CMD) ? ID_BYTE :
                     (rw_q ? 8'h00 : rd_data);

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        rx_d       = rx_q;
        tx_d       = tx_q;
        addr_d     = addr_q;
        rw_d       = rw_q;
        cpol_d     = cpol_q;
        cpha_d     = cpha_q;
        regs_d     = regs_q;
        wr_pulse_d = 1'b0;
        wr_addr_d  = wr_addr_q;

        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d   = CMD;
                    cpol_d    = CPOL;
                    cpha_d    = CPHA;
                    bit_cnt_d = 3'd0;
                    tx_d      = ID_BYTE;
                end
            end
            CMD, DATA: begin
                if (shift_edge) begin
                    tx_d = (bit_cnt_q == 3'd0) ? tx_load : {tx_q[6:0], 1'b0};
                end
                if (sample_edge) begin
                    rx_d      = shift_in[6:0];
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        if (state_q == CMD) begin
                            state_d = DATA;
                            addr_d  = shift_in[6:0];
                            rw_d    = shift_in[7];
                        end else begin
                            // out-of-range writes are dropped without a strobe
                            if (rw_q && in_range) begin
                                for (int n = 0; n < REG_COUNT; n++) begin
                                    if (addr_q == 7'(n)) regs_d[n] = shift_in;
                                end
                                wr_pulse_d = 1'b1;
                                wr_addr_d  = addr_q;
                            end
`ifdef SPI_RSP_AUTOINC_EN
                            addr_d = addr_q + 7'd1;
`else
                            state_d = DONE;
`endif
                        end
                    end
                end
            end
            DONE: begin
                // wait for CS to rise; SCLK activity is ignored
            end
            default: state_d = IDLE;
        endcase

        // deselect wins over everything except a write committed this cycle
        if (cs_rise) state_d = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync_q <= 2'b00;
            cs_sync_q   <= 2'b11;
            mosi_sync_q <= 2'b00;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
            state_q     <= IDLE;
            bit_cnt_q   <= 3'd0;
            rx_q        <= 7'd0;
            tx_q        <= 8'h00;
            addr_q      <= 7'd0;
            rw_q        <= 1'b0;
            cpol_q      <= 1'b0;
            cpha_q      <= 1'b0;
            regs_q      <= {REG_COUNT{RST_VAL}};
            wr_pulse_q  <= 1'b0;
            wr_addr_q   <= 7'd0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[0], SPI_SCLK};
            cs_sync_q   <= {cs_sync_q[0], CS};
            mosi_sync_q <= {mosi_sync_q[0], MOSI};
            sclk_prev_q <= sclk_s;
            cs_prev_q   <= cs_s;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            addr_q      <= addr_d;
            rw_q        <= rw_d;
            cpol_q      <= cpol_d;
            cpha_q      <= cpha_d;
            regs_q      <= regs_d;
            wr_pulse_q  <= wr_pulse_d;
            wr_addr_q   <= wr_addr_d;
        end
    end

    // outputs drop in the same clk that the synced CS rise is seen
    assign MISO     = ((state_q == CMD) || (state_q == DATA)) && !cs_s ? tx_q[7] : 1'b0;
    assign busy     = (state_q != IDLE) && !cs_s;
    assign wr_pulse = wr_pulse_q;
    assign wr_addr  = wr_addr_q;
    assign regs     = regs_q;

endmodule

// File: tb/tb_spi_reg_responder.sv
`timescale 1ns/1ps
module tb_spi_reg_responder;

    localparam int         RC   = 8;
    localparam logic [7:0] IDB  = 8'hA5;
    localparam logic [7:0] RSTV = 8'h00;
    localparam int         H    = 8;     // SCLK half period in clk cycles
`ifdef SPI_RSP_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst, sclk, cs, mosi, cpol, cpha;
    logic          miso, busy, wr_pulse;
    logic [6:0]    wr_addr;
    logic [8*RC-1:0] regs;

    int n_cmp = 0;
    int n_bad = 0;
    int pulse_total = 0;

    spi_reg_responder #(.REG_COUNT(RC), .ID_BYTE(IDB), .RST_VAL(RSTV)) dut (
        .clk(clk), .rst(rst), .SPI_SCLK(sclk), .CS(cs), .MOSI(mosi), .MISO(miso),
        .CPOL(cpol), .CPHA(cpha), .busy(busy), .wr_pulse(wr_pulse),
        .wr_addr(wr_addr), .regs(regs)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (wr_pulse === 1'b1) pulse_total <= pulse_total + 1;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    // ---------------- reference model (frame level) ----------------
    logic [7:0] m_regs [RC];
    logic [6:0] m_last;

    function automatic logic [63:0] model_vec();
        logic [63:0] v = '0;
        for (int n = 0; n < RC; n++) v[8*n +: 8] = m_regs[n];
        return v;
    endfunction

    task automatic model_reset();
        for (int n = 0; n < RC; n++) m_regs[n] = RSTV;
        m_last = 7'd0;
    endtask

    // Expected MISO bytes and writes for a frame of nbytes, nbits clocked.
    task automatic model_frame(input logic [3:0][7:0] tx, input int nbytes, input int nbits,
                               output logic [3:0][7:0] erx, output int ep);
        bit rw   = tx[0][7];
        int a    = int'(tx[0][6:0]);
        int full = nbits / 8;
        erx = '0;
        erx[0] = IDB;
        ep = 0;
        for (int k = 1; k < nbytes; k++) begin
            int ak = (a + k - 1) % 128;
            if (!AUTOINC && k > 1) begin
                erx[k] = 8'h00;
            end else begin
                erx[k] = (rw || ak >= RC) ? 8'h00 : m_regs[ak];
                if (rw && k < full && ak < RC) begin
                    m_regs[ak] = tx[k];
                    ep++;
                    m_last = 7'(ak);
                end
            end
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ---------------- SPI master ----------------
    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_start(input bit pol, input bit pha);
        cpol = pol; cpha = pha; sclk = pol; mosi = 1'b0;
        wait_clk(4);
        cs = 1'b0;
        wait_clk(H);
    endtask

    task automatic spi_bit(input bit pol, input bit pha, input logic b, output logic m);
        if (!pha) begin
            mosi = b; wait_clk(H);
            m = miso; sclk = ~pol; wait_clk(H);
            sclk = pol;
        end else begin
            sclk = ~pol; mosi = b; wait_clk(H);
            m = miso; sclk = pol; wait_clk(H);
        end
    endtask

    task automatic spi_end(input string tag);
        wait_clk(H);
        cs = 1'b1;
        wait_clk(6);
        chk({tag, "_busy_idle"}, 64'(busy), 64'd0);
        chk({tag, "_miso_idle"}, 64'(miso), 64'd0);
    endtask

    task automatic spi_frame(input bit pol, input bit pha, input logic [3:0][7:0] tx,
                             input int nbits, input string tag, output logic [3:0][7:0] rx);
        logic m;
        rx = '0;
        spi_start(pol, pha);
        for (int i = 0; i < nbits; i++) begin
            spi_bit(pol, pha, tx[i/8][7-(i%8)], m);
            rx[i/8][7-(i%8)] = m;
            if (i == 4) chk({tag, "_busy_mid"}, 64'(busy), 64'd1);
        end
        spi_end(tag);
    endtask

    typedef struct {
        bit               cpol;
        bit               cpha;
        int               nbytes;
        int               nbits;
        logic [3:0][7:0]  b;
        logic [7:0]       exp_rx0;
        logic [7:0]       exp_rx1;
        int               exp_pulses;
    } vec_t;

    function automatic vec_t mk(bit pol, bit pha, int nby, int nbi,
                                logic [7:0] b0, logic [7:0] b1, logic [7:0] b2, logic [7:0] b3,
                                logic [7:0] e0, logic [7:0] e1, int ep);
        vec_t v;
        v.cpol = pol; v.cpha = pha; v.nbytes = nby; v.nbits = nbi;
        v.b = {b3, b2, b1, b0};
        v.exp_rx0 = e0; v.exp_rx1 = e1; v.exp_pulses = ep;
        return v;
    endfunction

    // Runs one frame and checks it against the model; returns what was seen.
    task automatic run_vec(input vec_t v, input string tag,
                           output logic [3:0][7:0] rx, output int apulses);
        logic [3:0][7:0] erx;
        int ep;
        int p0 = pulse_total;
        spi_frame(v.cpol, v.cpha, v.b, v.nbits, tag, rx);
        apulses = pulse_total - p0;
        model_frame(v.b, v.nbytes, v.nbits, erx, ep);
        for (int k = 0; k < v.nbytes && k < v.nbits / 8; k++)
            chk($sformatf("%s_rx%0d", tag, k), 64'(rx[k]), 64'(erx[k]));
        chk({tag, "_pulses"}, 64'(apulses), 64'(ep));
        chk({tag, "_wr_addr"}, 64'(wr_addr), 64'(m_last));
        chk({tag, "_regs"}, regs, model_vec());
    endtask

    vec_t vecs [13];

    initial begin
        logic [3:0][7:0] rx;
        int              ap;
        logic            m;
        vec_t            v;

        rst = 1'b1; cs = 1'b1; sclk = 1'b0; mosi = 1'b0; cpol = 1'b0; cpha = 1'b0;
        model_reset();
        wait_clk(4);
        chk("rst_miso", 64'(miso), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_wr_pulse", 64'(wr_pulse), 64'd0);
        chk("rst_wr_addr", 64'(wr_addr), 64'd0);
        chk("rst_regs", regs, {RC{RSTV}});
        rst = 1'b0;
        wait_clk(4);

        // directed table: mode, length, bytes, expected MISO bytes and strobes
        vecs[0]  = mk(0, 0, 2, 16, 8'h83, 8'h5C, 8'h00, 8'h00, 8'hA5, 8'h00, 1);
        vecs[1]  = mk(0, 0, 2, 16, 8'h03, 8'h00, 8'h00, 8'h00, 8'hA5, 8'h5C, 0);
        vecs[2]  = mk(0, 1, 2, 16, 8'h03, 8'h00, 8'h00, 8'h00, 8'hA5, 8'h5C, 0);
        vecs[3]  = mk(1, 0, 2, 16, 8'h03, 8'h00, 8'h00, 8'h00, 8'hA5, 8'h5C, 0);
        vecs[4]  = mk(1, 1, 2, 16, 8'h03, 8'h00, 8'h00, 8'h00, 8'hA5, 8'h5C, 0);
        vecs[5]  = mk(0, 0, 2, 16, 8'h8A, 8'hFF, 8'h00, 8'h00, 8'hA5, 8'h00, 0);
        vecs[6]  = mk(0, 1, 2, 16, 8'h0A, 8'h00, 8'h00, 8'h00, 8'hA5, 8'h00, 0);
        vecs[7]  = mk(0, 0, 4, 32, 8'h86, 8'h11, 8'h22, 8'h33, 8'hA5, 8'h00, AUTOINC ? 2 : 1);
        vecs[8]  = mk(1, 1, 2, 16, 8'h07, 8'h00, 8'h00, 8'h00, 8'hA5, AUTOINC ? 8'h22 : 8'h00, 0);
        vecs[9]  = mk(1, 0, 2, 12, 8'h81, 8'hF0, 8'h00, 8'h00, 8'hA5, 8'h00, 0); // abort
        vecs[10] = mk(0, 0, 2, 16, 8'h01, 8'h00, 8'h00, 8'h00, 8'hA5, 8'h00, 0);
        vecs[11] = mk(0, 1, 2, 16, 8'h81, 8'h77, 8'h00, 8'h00, 8'hA5, 8'h00, 1);
        vecs[12] = mk(1, 1, 2, 16, 8'h01, 8'h00, 8'h00, 8'h00, 8'hA5, 8'h77, 0);

        for (int i = 0; i < 13; i++) begin
            string tag = $sformatf("vec%0d", i);
            run_vec(vecs[i], tag, rx, ap);
            chk({tag, "_tbl_rx0"}, 64'(rx[0]), 64'(vecs[i].exp_rx0));
            if (vecs[i].nbits >= 16)
                chk({tag, "_tbl_rx1"}, 64'(rx[1]), 64'(vecs[i].exp_rx1));
            chk({tag, "_tbl_pulses"}, 64'(ap), 64'(vecs[i].exp_pulses));
        end

        // asynchronous reset in the middle of a read frame
        v = mk(0, 0, 2, 16, 8'h82, 8'hA9, 8'h00, 8'h00, 8'hA5, 8'h00, 1);
        run_vec(v, "pre_rst", rx, ap);
        spi_start(0, 0);
        for (int i = 0; i < 10; i++) begin
            logic [15:0] fr = 16'h0200;
            spi_bit(0, 0, fr[15-i], m);
        end
        wait_clk(H);
        chk("midrd_miso", 64'(miso), 64'd1);   // bit 5 of 8'hA9
        chk("midrd_busy", 64'(busy), 64'd1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_miso", 64'(miso), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_regs", regs, {RC{RSTV}});
        chk("arst_wr_addr", 64'(wr_addr), 64'd0);
        cs = 1'b1; sclk = 1'b0;
        wait_clk(3);
        rst = 1'b0;
        model_reset();
        wait_clk(4);

        // randomized frames against the model
        for (int i = 0; i < 20; i++) begin
            logic [7:0] cmd;
            cmd = {1'($urandom_range(0, 1)), 7'($urandom_range(0, 11))};
            v = mk(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   $urandom_range(2, 3), 0, cmd, 8'($urandom), 8'($urandom), 8'h00,
                   8'h00, 8'h00, 0);
            v.nbits = 8 * v.nbytes;
            run_vec(v, $sformatf("rnd%0d", i), rx, ap);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
